// File: rtl/dromajo_ram_initiator.sv
// Valid/ready request front end driving a dromajo_ram port with in-order responses.
// Optional write acknowledges: define DROMAJO_RAM_INITIATOR_WRACK_EN.
module dromajo_ram_initiator #(
  parameter int ADDR_WIDTH = 10,
  parameter int OUT_REGS   = 0,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                  Clk_CI,
  input  logic                  Rst_RBI,
  input  logic                  ReqValid_SI,
  output logic                  ReqReady_SO,
  input  logic                  ReqWrite_SI,
  input  logic [ADDR_WIDTH-1:0] ReqAddr_DI,
  input  logic [7:0]            ReqBEn_SI,
  input  logic [63:0]           ReqData_DI,
  output logic                  RspValid_SO,
  input  logic                  RspReady_SI,
  output logic                  RspWrite_SO,
  output logic [63:0]           RspData_DO,
  output logic                  CSel_SO,
  output logic                  WrEn_SO,
  output logic [7:0]            BEn_SO,
  output logic [63:0]           WrData_DO,
  output logic [ADDR_WIDTH-1:0] Addr_DO,
  input  logic [63:0]           RdData_DI
);

  localparam int L  = 1 + OUT_REGS;
  localparam int PW = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int CW = $clog2(RSP_DEPTH + L + 2) + 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(RSP_DEPTH - 1);
  localparam logic [CW-1:0] DEPTH_C  = CW'(RSP_DEPTH);

  if (RSP_DEPTH < L + 1) begin : g_bad_depth
    $error("dromajo_ram_initiator: RSP_DEPTH below read latency + 1");
  end

  logic                  w_accept;
  logic                  w_acc_wr;
  logic                  w_acc_rd;
  logic                  w_wr_rsp;
  logic                  w_csel_n;
  logic                  w_wren_n;
  logic                  w_resp_n;
  logic [7:0]            w_ben_n;

  logic                  r_csel;
  logic                  r_wren;
  logic                  r_resp;
  logic [7:0]            r_ben;
  logic [63:0]           r_wdata;
  logic [ADDR_WIDTH-1:0] r_addr;

  logic [L-1:0]          r_pipe_v;
  logic [L-1:0]          r_pipe_w;

  logic [63:0]           r_fifo_d [RSP_DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_cnt;

  logic                  w_push;
  logic                  w_push_wr;
  logic [63:0]           w_push_data;
  logic                  w_pop;
  logic [CW-1:0]         w_pipe_cnt;
  logic [CW-1:0]         w_outst;

`ifdef DROMAJO_RAM_INITIATOR_WRACK_EN
  logic [RSP_DEPTH-1:0]  r_fifo_w;
  assign w_wr_rsp = 1'b1;
`else
  assign w_wr_rsp = 1'b0;
`endif

  assign w_accept = ReqValid_SI & ReqReady_SO;
  assign w_acc_wr = w_accept & ReqWrite_SI;
  assign w_acc_rd = w_accept & ~ReqWrite_SI;

  always_comb begin
    w_csel_n = 1'b0;
    w_wren_n = 1'b0;
    w_resp_n = 1'b0;
    w_ben_n  = '0;
    unique case (1'b1)
      w_acc_wr: begin
        w_csel_n = 1'b1;
        w_wren_n = 1'b1;
        w_resp_n = w_wr_rsp;
        w_ben_n  = ReqBEn_SI;
      end
      w_acc_rd: begin
        w_csel_n = 1'b1;
        w_resp_n = 1'b1;
      end
      default: ;
    endcase
  end

  // Address and write data hold their last value while idle.
  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_csel  <= 1'b0;
      r_wren  <= 1'b0;
      r_resp  <= 1'b0;
      r_ben   <= '0;
      r_wdata <= '0;
      r_addr  <= '0;
    end else begin
      r_csel <= w_csel_n;
      r_wren <= w_wren_n;
      r_resp <= w_resp_n;
      r_ben  <= w_ben_n;
      if (w_accept) r_addr <= ReqAddr_DI;
      if (w_acc_wr) r_wdata <= ReqData_DI;
    end
  end

  assign CSel_SO   = r_csel;
  assign WrEn_SO   = r_wren;
  assign BEn_SO    = r_ben;
  assign WrData_DO = r_wdata;
  assign Addr_DO   = r_addr;

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      r_pipe_v <= '0;
      r_pipe_w <= '0;
    end else begin
      r_pipe_v[0] <= r_csel & r_resp;
      r_pipe_w[0] <= r_wren;
      for (int i = 1; i < L; i++) begin
        r_pipe_v[i] <= r_pipe_v[i-1];
        r_pipe_w[i] <= r_pipe_w[i-1];
      end
    end
  end

  assign w_push      = r_pipe_v[L-1];
  assign w_push_wr   = r_pipe_w[L-1];
  assign w_push_data = w_push_wr ? 64'h0 : RdData_DI;
  assign w_pop       = RspValid_SO & RspReady_SI;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PTR_LAST) ? '0 : p + 1'b1;
  endfunction

  always_ff @(posedge Clk_CI or negedge Rst_RBI) begin
    if (!Rst_RBI) begin
      for (int i = 0; i < RSP_DEPTH; i++) r_fifo_d[i] <= '0;
`ifdef DROMAJO_RAM_INITIATOR_WRACK_EN
      r_fifo_w <= '0;
`endif
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
    end else begin
      if (w_push) begin
        r_fifo_d[r_wptr] <= w_push_data;
`ifdef DROMAJO_RAM_INITIATOR_WRACK_EN
        r_fifo_w[r_wptr] <= w_push_wr;
`endif
        r_wptr <= ptr_inc(r_wptr);
      end
      if (w_pop) r_rptr <= ptr_inc(r_rptr);
      unique case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: ;
      endcase
    end
  end

  assign RspValid_SO = (r_cnt != '0);
  assign RspData_DO  = r_fifo_d[r_rptr];
`ifdef DROMAJO_RAM_INITIATOR_WRACK_EN
  assign RspWrite_SO = r_fifo_w[r_rptr];
`else
  assign RspWrite_SO = 1'b0;
`endif

  // A slot stays reserved from command issue until its response is popped.
  always_comb begin
    w_pipe_cnt = '0;
    for (int i = 0; i < L; i++) begin
      w_pipe_cnt = w_pipe_cnt + CW'(r_pipe_v[i]);
    end
  end

  assign w_outst     = w_pipe_cnt + r_cnt + CW'(r_csel & r_resp);
  assign ReqReady_SO = (w_outst < DEPTH_C);

  a_no_overflow: assert property (
    @(posedge Clk_CI) disable iff (!Rst_RBI)
    !(w_push && !w_pop && (r_cnt == DEPTH_C))
  );

endmodule
